// File: rtl/tone_classifier_pkg.sv
// Shared encodings, FSM states and period-window arithmetic for the tone period classifier.
package tone_classifier_pkg;

  localparam logic [1:0] CLASS_NONE = 2'd0;
  localparam logic [1:0] CLASS_F0   = 2'd1;
  localparam logic [1:0] CLASS_F1   = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_e;

  typedef struct packed {
    int unsigned min0;
    int unsigned max0;
    int unsigned min1;
    int unsigned max1;
    int unsigned timeout;
  } window_t;

  // Period windows in clock cycles; integer division truncates toward zero.
  function automatic window_t calc_windows(input int unsigned clk_hz,
                                           input int unsigned f0_hz,
                                           input int unsigned f1_hz,
                                           input int unsigned dev_hz);
    window_t w;
    w.min0    = clk_hz / (f0_hz + dev_hz);
    w.max0    = clk_hz / (f0_hz - dev_hz);
    w.min1    = clk_hz / (f1_hz + dev_hz);
    w.max1    = clk_hz / (f1_hz - dev_hz);
    w.timeout = (w.max0 > w.max1) ? w.max0 : w.max1;
    return w;
  endfunction

endpackage

// File: rtl/tone_edge_conditioner.sv
// Brings the pixel MSB into the clock domain and flags its rising edges.
// Optional persistence filter enabled by TONE_CLASSIFIER_GLITCH_FILTER_EN.
module tone_edge_conditioner #(
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic clk_i,
  input  logic srst_n_i,
  input  logic sample_i,
  output logic rise_o
);

`ifdef TONE_CLASSIFIER_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // NOTE: non-blocking assignments so each flop takes the previous stage's old value on the same edge.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sample_i;
      sync2_q <= sync1_q;
    end
  end

  if (FILTER_EN && (GLITCH_CYCLES > 0)) begin : g_filter
    localparam int unsigned CW = $clog2(GLITCH_CYCLES + 1);
    logic [CW-1:0] run_q;
    logic          filt_q;

    // Level flips only after GLITCH_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
        run_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync2_q == filt_q) begin
        run_q <= '0;
      end else if (run_q == CW'(GLITCH_CYCLES - 1)) begin
        run_q  <= '0;
        filt_q <= sync2_q;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end

    assign level = filt_q;
  end else begin : g_bypass
    assign level = sync2_q;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) prev_q <= 1'b0;
    else           prev_q <= level;
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/tone_period_classifier.sv
// Measures rise-to-rise periods of one pixel stream and accumulates time spent on each target tone.
// Glitch filter in the edge path is enabled by TONE_CLASSIFIER_GLITCH_FILTER_EN.
module tone_period_classifier
  import tone_classifier_pkg::*;
#(
  parameter int unsigned FREQUENCY0          = 9000,
  parameter int unsigned FREQUENCY1          = 11000,
  parameter int unsigned FREQUENCY_DEVIATION = 10,
  parameter int unsigned CLOCK_FREQUENCY     = 100000000,
  parameter int unsigned VALUE_WIDTH         = 32,
  parameter int unsigned GLITCH_CYCLES       = 3
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic                   sample_data,
  input  logic                   enable,
  input  logic                   clear,
  output logic [VALUE_WIDTH-1:0] f0_value,
  output logic [VALUE_WIDTH-1:0] f1_value,
  output logic                   period_valid,
  output logic [1:0]             period_class
);

  localparam window_t WIN = calc_windows(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY1,
                                         FREQUENCY_DEVIATION);

  localparam logic [VALUE_WIDTH-1:0] MIN0    = VALUE_WIDTH'(WIN.min0);
  localparam logic [VALUE_WIDTH-1:0] MAX0    = VALUE_WIDTH'(WIN.max0);
  localparam logic [VALUE_WIDTH-1:0] MIN1    = VALUE_WIDTH'(WIN.min1);
  localparam logic [VALUE_WIDTH-1:0] MAX1    = VALUE_WIDTH'(WIN.max1);
  localparam logic [VALUE_WIDTH-1:0] TIMEOUT = VALUE_WIDTH'(WIN.timeout);
  localparam logic [VALUE_WIDTH-1:0] ONE     = VALUE_WIDTH'(1);

  logic                   srst_n;
  logic                   rise;
  state_e                 state_q;
  logic [VALUE_WIDTH-1:0] count_q;
  logic [VALUE_WIDTH-1:0] f0_q;
  logic [VALUE_WIDTH-1:0] f1_q;
  logic                   valid_q;
  logic [1:0]             class_q;
  logic [1:0]             match_class_d;

  // Clear behaves exactly like reset, including the synchronizer.
  assign srst_n = s00_axi_aresetn & clear;

  tone_edge_conditioner #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_edge (
    .clk_i    (s00_axi_aclk),
    .srst_n_i (srst_n),
    .sample_i (sample_data),
    .rise_o   (rise)
  );

  function automatic logic [VALUE_WIDTH-1:0] sat_add(input logic [VALUE_WIDTH-1:0] a,
                                                     input logic [VALUE_WIDTH-1:0] b);
    logic [VALUE_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[VALUE_WIDTH] ? '1 : sum[VALUE_WIDTH-1:0];
  endfunction

  // f0 is tested first so it wins where the windows overlap.
  always_comb begin
    match_class_d = CLASS_NONE;
    if ((count_q >= MIN0) && (count_q <= MAX0))      match_class_d = CLASS_F0;
    else if ((count_q >= MIN1) && (count_q <= MAX1)) match_class_d = CLASS_F1;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!srst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      f0_q    <= '0;
      f1_q    <= '0;
      valid_q <= 1'b0;
      class_q <= CLASS_NONE;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q <= '0;
            state_q <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              count_q <= ONE;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            // A rise on the timeout cycle is still classified; only an edgeless overrun drops the tone.
            if (rise) begin
              valid_q <= 1'b1;
              class_q <= match_class_d;
              if (match_class_d == CLASS_F0) f0_q <= sat_add(f0_q, count_q);
              if (match_class_d == CLASS_F1) f1_q <= sat_add(f1_q, count_q);
              count_q <= ONE;
            end else if (count_q > TIMEOUT) begin
              count_q <= '0;
              state_q <= WAIT_EDGE;
            end else begin
              count_q <= count_q + ONE;
            end
          end
          default: begin
            count_q <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign f0_value     = f0_q;
  assign f1_value     = f1_q;
  assign period_valid = valid_q;
  assign period_class = class_q;

endmodule

// File: tb/tb_tone_period_classifier.sv
// Scoreboard bench for tone_period_classifier: a 32-bit and an 8-bit instance share one stimulus stream.
module tb_tone_period_classifier;
  import tone_classifier_pkg::*;

  localparam int unsigned CLK_HZ  = 1000000;
  localparam int unsigned F0_HZ   = 10000;
  localparam int unsigned F1_HZ   = 20000;
  localparam int unsigned DEV_HZ  = 10;
  localparam longint      MIN0    = CLK_HZ / (F0_HZ + DEV_HZ);
  localparam longint      MAX0    = CLK_HZ / (F0_HZ - DEV_HZ);
  localparam longint      MIN1    = CLK_HZ / (F1_HZ + DEV_HZ);
  localparam longint      MAX1    = CLK_HZ / (F1_HZ - DEV_HZ);
  localparam longint      TIMEOUT = (MAX0 > MAX1) ? MAX0 : MAX1;
  localparam longint      SAT32   = 64'hFFFF_FFFF;
  localparam longint      SAT8    = 255;
  localparam time         T_CLK   = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample;
  logic        enable;
  logic        clr;
  logic [31:0] f0_v;
  logic [31:0] f1_v;
  logic        pv;
  logic [1:0]  pc;
  logic [7:0]  f0_8;
  logic [7:0]  f1_8;
  logic        pv8;
  logic [1:0]  pc8;

  always #(T_CLK / 2) clk = ~clk;

  tone_period_classifier #(
    .FREQUENCY0 (F0_HZ), .FREQUENCY1 (F1_HZ), .FREQUENCY_DEVIATION (DEV_HZ),
    .CLOCK_FREQUENCY (CLK_HZ), .VALUE_WIDTH (32), .GLITCH_CYCLES (3)
  ) dut (
    .s00_axi_aclk (clk), .s00_axi_aresetn (rst_n), .sample_data (sample),
    .enable (enable), .clear (clr), .f0_value (f0_v), .f1_value (f1_v),
    .period_valid (pv), .period_class (pc)
  );

  tone_period_classifier #(
    .FREQUENCY0 (F0_HZ), .FREQUENCY1 (F1_HZ), .FREQUENCY_DEVIATION (DEV_HZ),
    .CLOCK_FREQUENCY (CLK_HZ), .VALUE_WIDTH (8), .GLITCH_CYCLES (3)
  ) dut8 (
    .s00_axi_aclk (clk), .s00_axi_aresetn (rst_n), .sample_data (sample),
    .enable (enable), .clear (clr), .f0_value (f0_8), .f1_value (f1_8),
    .period_valid (pv8), .period_class (pc8)
  );

  typedef struct {
    int     cls;
    longint f0;
    longint f1;
    longint f0_8;
    longint f1_8;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     m_meas   = 1'b0;
  time    t_last   = 0;
  longint m_f0 = 0, m_f1 = 0, m_f0_8 = 0, m_f1_8 = 0;

  function automatic int classify(input longint p);
    if (p >= MIN0 && p <= MAX0) return 1;
    if (p >= MIN1 && p <= MAX1) return 2;
    return 0;
  endfunction

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_clear();
    m_meas = 1'b0;
    m_f0 = 0; m_f1 = 0; m_f0_8 = 0; m_f1_8 = 0;
  endtask

  task automatic low(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a rising edge; the model decides whether it closes a period.
  task automatic rise(input int high_cycles = 10);
    longint gap;
    int     cls;
    exp_t   e;
    gap = longint'(($time - t_last) / T_CLK);
    if (m_meas && gap <= TIMEOUT + 1) begin
      cls = classify(gap);
      if (cls == 1) begin m_f0 = sat(m_f0 + gap, SAT32); m_f0_8 = sat(m_f0_8 + gap, SAT8); end
      if (cls == 2) begin m_f1 = sat(m_f1 + gap, SAT32); m_f1_8 = sat(m_f1_8 + gap, SAT8); end
      e.cls = cls; e.f0 = m_f0; e.f1 = m_f1; e.f0_8 = m_f0_8; e.f1_8 = m_f1_8;
      sb.push_back(e);
    end
    m_meas = enable;
    t_last = $time;
    sample = 1'b1;
    repeat (high_cycles) @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (!v) m_meas = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_clear();
    low(3);
  endtask

  task automatic drain(input string name);
    low(8);
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_missing_pulses: %0d expected pulses never seen", name, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pv || pv8) begin
        n_checks++;
        if (pv !== pv8) $display("FAIL pulse_align: pv=%b pv8=%b", pv, pv8);
        else n_pass++;
      end
      if (pv === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_pulse at %0t: class=%0d f0=%0d f1=%0d", $time, pc, f0_v, f1_v);
        end else begin
          n_pass++;
          e = sb.pop_front();
          n_checks++;
          if (pc !== 2'(e.cls)) $display("FAIL pulse_class: got %0d expected %0d", pc, e.cls);
          else n_pass++;
          n_checks++;
          if (f0_v !== 32'(e.f0) || f1_v !== 32'(e.f1))
            $display("FAIL pulse_acc32: got f0=%0d f1=%0d expected f0=%0d f1=%0d", f0_v, f1_v, e.f0, e.f1);
          else n_pass++;
          n_checks++;
          if (f0_8 !== 8'(e.f0_8) || f1_8 !== 8'(e.f1_8) || pc8 !== 2'(e.cls))
            $display("FAIL pulse_acc8: got f0=%0d f1=%0d cls=%0d expected f0=%0d f1=%0d cls=%0d",
                     f0_8, f1_8, pc8, e.f0_8, e.f1_8, e.cls);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b1; enable = 1'b0; sample = 1'b0;
    low(3);
    n_checks++;
    if (f0_v !== '0 || f1_v !== '0 || pv !== 1'b0 || pc !== 2'd0)
      $display("FAIL reset_outputs: f0=%0d f1=%0d pv=%b pc=%0d expected all 0", f0_v, f1_v, pv, pc);
    else n_pass++;
    n_checks++;
    if (f0_8 !== '0 || f1_8 !== '0 || pv8 !== 1'b0 || pc8 !== 2'd0)
      $display("FAIL reset_outputs8: f0=%0d f1=%0d pv=%b pc=%0d expected all 0", f0_8, f1_8, pv8, pc8);
    else n_pass++;
    rst_n = 1'b1;
    model_clear();
    set_enable(1'b1);
    low(3);
  endtask

  task automatic test_f0();
    do_clear();
    for (int i = 0; i < 5; i++) begin rise(); low(90); end
    drain("f0");
    n_checks++;
    if (f0_v !== 32'd400 || f1_v !== 32'd0)
      $display("FAIL f0_total: got f0=%0d f1=%0d expected f0=400 f1=0", f0_v, f1_v);
    else n_pass++;
  endtask

  task automatic test_f1_nomatch();
    do_clear();
    for (int i = 0; i < 3; i++) begin rise(); low(40); end
    low(51);
    rise(); low(91);
    rise(); low(20);
    drain("f1_nomatch");
    n_checks++;
    if (f1_v !== 32'd100 || f0_v !== 32'd0)
      $display("FAIL f1_total: got f0=%0d f1=%0d expected f0=0 f1=100", f0_v, f1_v);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_clear();
    rise(); low(140);
    rise(); low(90);
    rise(); low(20);
    drain("timeout");
    n_checks++;
    if (f0_v !== 32'd100) $display("FAIL timeout_total: got f0=%0d expected 100", f0_v);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 6; i++) begin rise(); low(90); end
    drain("saturation");
    n_checks++;
    if (f0_8 !== 8'd255) $display("FAIL sat8_hold: got f0=%0d expected 255", f0_8);
    else n_pass++;
    n_checks++;
    if (f0_v !== 32'd500) $display("FAIL sat32_ref: got f0=%0d expected 500", f0_v);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    do_clear();
    rise(); low(90);
    rise(); low(90);
    rise(); low(30);
    set_enable(1'b0);
    low(20);
    n_checks++;
    if (f0_v !== 32'd200) $display("FAIL enable_hold: got f0=%0d expected 200", f0_v);
    else n_pass++;
    set_enable(1'b1);
    low(30);
    rise(); low(5);
    n_checks++;
    if (f0_v !== 32'd200 || pv !== 1'b0)
      $display("FAIL reenable_first_rise: got f0=%0d pv=%b expected f0=200 pv=0", f0_v, pv);
    else n_pass++;
    low(85);
    rise(); low(20);
    drain("enable_drop");
  endtask

  task automatic test_clear_reset();
    do_clear();
    rise(); low(90);
    rise(); low(20);
    drain("pre_clear");
    clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f0_v !== '0 || f1_v !== '0 || pv !== 1'b0 || pc !== 2'd0 || dut.state_q !== IDLE)
      $display("FAIL clear_outputs: f0=%0d f1=%0d pv=%b pc=%0d state=%0d expected 0/IDLE",
               f0_v, f1_v, pv, pc, dut.state_q);
    else n_pass++;
    clr = 1'b1;
    model_clear();
    low(3);
    rise(); low(90);
    rise(); low(30);
    drain("pre_reset");
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f0_v !== '0 || f1_v !== '0 || pv !== 1'b0 || pc !== 2'd0 || dut.state_q !== IDLE)
      $display("FAIL reset_mid_measure: f0=%0d f1=%0d pv=%b pc=%0d state=%0d expected 0/IDLE",
               f0_v, f1_v, pv, pc, dut.state_q);
    else n_pass++;
    rst_n = 1'b1;
    model_clear();
    low(3);
    rise(); low(90);
    rise(); low(20);
    drain("post_reset");
    n_checks++;
    if (f0_v !== 32'd100) $display("FAIL post_reset_total: got f0=%0d expected 100", f0_v);
    else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_f0();
    test_f1_nomatch();
    test_timeout();
    test_saturation();
    test_enable_drop();
    test_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
